// File: rtl/alu_vec_pipe.sv
// alu_vec_pipe: two-stage pipelined vector ALU. It applies one operation to
// N_LANES independent WIDTH-bit lanes per transaction. It supports a
// valid/ready handshake, per-lane masking, saturating arithmetic and a
// per-lane accumulator.
// S1 registers the operands and control. S2 computes the lane results and
// registers them, which makes all outputs come straight from flops.
module alu_vec_pipe #(
    parameter int WIDTH   = 4,
    parameter int N_LANES = 4
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_LANES*WIDTH-1:0]   a,
    input  logic [N_LANES*WIDTH-1:0]   b,
    input  logic [2:0]                 select,
    input  logic                       sat_en,
    input  logic [N_LANES-1:0]         lane_mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_LANES*WIDTH-1:0]   data_out,
    output logic [N_LANES-1:0]         carry_out,
    output logic [N_LANES-1:0]         a_greater,
    output logic [N_LANES-1:0]         a_equal,
    output logic [N_LANES-1:0]         a_less
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_MAX = 3'd6;
    localparam logic [2:0] OP_ACC = 3'd7;

    // Stage 1 holding registers
    logic                     s1_valid_q;
    logic [N_LANES*WIDTH-1:0] s1_a_q;
    logic [N_LANES*WIDTH-1:0] s1_b_q;
    logic [2:0]               s1_op_q;
    logic                     s1_sat_q;
    logic [N_LANES-1:0]       s1_mask_q;

    // Stage 2 valid. The S2 result registers live inside each lane.
    logic                     s2_valid_q;

    logic s2_adv;
    logic s1_adv;
    logic accept;

    // The handshake uses no skid buffer. in_ready follows out_ready combinationally.
    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = s1_valid_q && s2_adv;
    assign in_ready  = !s1_valid_q || s2_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid_q;

    // S1: capture operands and control on every accepted transaction
    always_ff @(posedge clk) begin
        if (arst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_ADD;
            s1_sat_q   <= 1'b0;
            s1_mask_q  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (accept) begin
                s1_a_q    <= a;
                s1_b_q    <= b;
                s1_op_q   <= select;
                s1_sat_q  <= sat_en;
                s1_mask_q <= lane_mask;
            end
        end
    end

    // S2 valid: S2 loads from S1 whenever it is empty or being drained
    always_ff @(posedge clk) begin
        if (arst) begin
            s2_valid_q <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic [WIDTH-1:0] a_l;
            logic [WIDTH-1:0] b_l;
            logic             lane_en;
            logic [WIDTH-1:0] acc_q;
            logic [WIDTH:0]   sum_w;
            logic [WIDTH:0]   diff_w;
            logic [WIDTH:0]   acc_w;
            logic [WIDTH-1:0] res_d;
            logic             carry_d;
            logic             gt_d;
            logic             eq_d;
            logic             lt_d;
            logic [WIDTH-1:0] data_q;
            logic             carry_q;
            logic             gt_q;
            logic             eq_q;
            logic             lt_q;

            assign a_l     = s1_a_q[gi*WIDTH +: WIDTH];
            assign b_l     = s1_b_q[gi*WIDTH +: WIDTH];
            assign lane_en = s1_mask_q[gi];

            // Lane datapath: one extra bit on each adder exposes the raw carry/borrow
            always_comb begin
                sum_w   = {1'b0, a_l} + {1'b0, b_l};
                diff_w  = {1'b0, a_l} - {1'b0, b_l};
                acc_w   = {1'b0, acc_q} + {1'b0, a_l};
                res_d   = '0;
                carry_d = 1'b0;
                case (s1_op_q)
                    OP_ADD: begin
                        res_d   = (s1_sat_q && sum_w[WIDTH]) ? '1 : sum_w[WIDTH-1:0];
                        carry_d = sum_w[WIDTH];
                    end
                    OP_SUB: begin
                        res_d   = (s1_sat_q && diff_w[WIDTH]) ? '0 : diff_w[WIDTH-1:0];
                        carry_d = diff_w[WIDTH];
                    end
                    OP_AND: res_d = a_l & b_l;
                    OP_OR:  res_d = a_l | b_l;
                    OP_XOR: res_d = a_l ^ b_l;
                    OP_NOT: res_d = ~a_l;
                    OP_MAX: res_d = (a_l > b_l) ? a_l : b_l;
                    OP_ACC: begin
                        res_d   = (s1_sat_q && acc_w[WIDTH]) ? '1 : acc_w[WIDTH-1:0];
                        carry_d = acc_w[WIDTH];
                    end
                    default: res_d = '0;
                endcase
                gt_d = a_l > b_l;
                eq_d = a_l == b_l;
                lt_d = a_l < b_l;
                if (!lane_en) begin
                    res_d   = '0;
                    carry_d = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                end
            end

            // Result registers load only on an S1->S2 transfer, so they hold while stalled
            always_ff @(posedge clk) begin
                if (arst) begin
                    data_q  <= '0;
                    carry_q <= 1'b0;
                    gt_q    <= 1'b0;
                    eq_q    <= 1'b0;
                    lt_q    <= 1'b0;
                end else if (s1_adv) begin
                    data_q  <= res_d;
                    carry_q <= carry_d;
                    gt_q    <= gt_d;
                    eq_q    <= eq_d;
                    lt_q    <= lt_d;
                end
            end

            // The accumulator commits with the transfer. The next ACC in S1 therefore reads the updated value.
            always_ff @(posedge clk) begin
                if (arst) begin
                    acc_q <= '0;
                end else if (s1_adv && (s1_op_q == OP_ACC) && lane_en) begin
                    acc_q <= res_d;
                end
            end

            assign data_out[gi*WIDTH +: WIDTH] = data_q;
            assign carry_out[gi]               = carry_q;
            assign a_greater[gi]               = gt_q;
            assign a_equal[gi]                 = eq_q;
            assign a_less[gi]                  = lt_q;
        end
    endgenerate

endmodule

// File: tb/tb_alu_vec_pipe.sv
// Testbench for alu_vec_pipe (WIDTH=4, N_LANES=4). A per-transaction reference
// model records its expected results in a queue when each transaction is accepted.
// The outputs actually delivered are recorded when each result is handed off.
// Each test task compares the two.
module tb_alu_vec_pipe;
    localparam int NL = 4;

    logic        clk;
    logic        arst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  select;
    logic        sat_en;
    logic [3:0]  lane_mask;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic [3:0]  carry_out;
    logic [3:0]  a_greater;
    logic [3:0]  a_equal;
    logic [3:0]  a_less;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  cy;
        logic [3:0]  gt;
        logic [3:0]  eq;
        logic [3:0]  lt;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    int   acc_m[NL];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    int   smp_cyc;
    logic smp_accept;
    logic smp_fire;
    logic smp_ovalid;

    alu_vec_pipe #(.WIDTH(4), .N_LANES(4)) dut (
        .clk(clk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .select(select), .sat_en(sat_en), .lane_mask(lane_mask),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .carry_out(carry_out), .a_greater(a_greater), .a_equal(a_equal), .a_less(a_less)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: computes the result of the transaction on the inputs with plain integer arithmetic
    task automatic model_push();
        res_t r;
        int av, bv, s, rv, c;
        r = '0;
        for (int i = 0; i < NL; i++) begin
            av = int'(a[i*4 +: 4]);
            bv = int'(b[i*4 +: 4]);
            if (lane_mask[i]) begin
                r.gt[i] = (av > bv);
                r.eq[i] = (av == bv);
                r.lt[i] = (av < bv);
                c = 0;
                rv = 0;
                case (select)
                    3'd0: begin s = av + bv; c = (s > 15) ? 1 : 0; rv = (sat_en && c != 0) ? 15 : s % 16; end
                    3'd1: begin c = (av < bv) ? 1 : 0; rv = (sat_en && c != 0) ? 0 : (av - bv + 16) % 16; end
                    3'd2: rv = av & bv;
                    3'd3: rv = av | bv;
                    3'd4: rv = av ^ bv;
                    3'd5: rv = 15 - av;
                    3'd6: rv = (av > bv) ? av : bv;
                    default: begin
                        s = acc_m[i] + av;
                        c = (s > 15) ? 1 : 0;
                        rv = (sat_en && c != 0) ? 15 : s % 16;
                        acc_m[i] = rv;
                    end
                endcase
                r.data[i*4 +: 4] = 4'(rv);
                r.cy[i] = (c != 0);
            end
        end
        exp_q.push_back(r);
    endtask

    // Advances one cycle. Inputs are set by the caller at the falling edge.
    task automatic tick();
        #1;
        smp_cyc    = cyc;
        smp_accept = !arst && in_valid && in_ready;
        smp_fire   = !arst && out_valid && out_ready;
        smp_ovalid = out_valid;
        if (smp_fire) obs_q.push_back({data_out, carry_out, a_greater, a_equal, a_less});
        if (smp_accept) model_push();
        @(posedge clk);
        cyc++;
        if (arst) begin
            for (int i = 0; i < NL; i++) acc_m[i] = 0;
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        arst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        arst = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    // Holds a transaction on the inputs until it is accepted. The wait is bounded.
    task automatic drive_txn(input logic [15:0] ta, input logic [15:0] tb_v, input logic [2:0] op,
                             input logic s, input logic [3:0] m);
        logic done;
        done = 1'b0;
        a = ta; b = tb_v; select = op; sat_en = s; lane_mask = m; in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (smp_accept) begin done = 1'b1; break; end
        end
        in_valid = 1'b0;
        if (!done) begin
            total_cnt++;
            $display("FAIL accept_timeout: in_ready never seen, txn a=%h op=%0d", ta, op);
        end
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (data_out !== 16'h0) $display("FAIL rst_data: got %h want 0000", data_out); else pass_cnt++;
        total_cnt++;
        if ({carry_out, a_greater, a_equal, a_less} !== 16'h0)
            $display("FAIL rst_flags: got %h want 0000", {carry_out, a_greater, a_equal, a_less});
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [15:0] va[4] = '{16'h9F3A, 16'h9F3A, 16'h1234, 16'h1234};
        logic [15:0] vb[4] = '{16'h1234, 16'h1234, 16'h9F3A, 16'h9F3A};
        logic [2:0]  vo[4] = '{3'd0, 3'd0, 3'd1, 3'd1};
        logic        vs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] vd[4] = '{16'hA16E, 16'hAF6E, 16'h830A, 16'h0000};
        logic [3:0]  vc[4] = '{4'b0100, 4'b0100, 4'b1101, 4'b1101};
        res_t r;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_txn(va[k], vb[k], vo[k], vs[k], 4'hF);
            drain();
            r = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            total_cnt++; if (r.data !== vd[k]) $display("FAIL dir%0d_data: got %h want %h", k, r.data, vd[k]); else pass_cnt++;
            total_cnt++; if (r.cy !== vc[k]) $display("FAIL dir%0d_carry: got %b want %b", k, r.cy, vc[k]); else pass_cnt++;
            if (k == 0) begin
                total_cnt++;
                if ({r.gt, r.eq, r.lt} !== {4'b1101, 4'b0010, 4'b0000})
                    $display("FAIL dir0_flags: got %b want 110100100000", {r.gt, r.eq, r.lt});
                else pass_cnt++;
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_acc();
        logic [15:0] va[7] = '{16'h1111, 16'h1111, 16'h1111, 16'hCCCC, 16'hCCCC, 16'h1111, 16'h0000};
        logic        vs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  vm[7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0101, 4'hF};
        logic [15:0] vd[7] = '{16'h1111, 16'h2222, 16'h3333, 16'hFFFF, 16'hFFFF, 16'h0F0F, 16'hFFFF};
        logic [3:0]  vc[7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'b0101, 4'h0};
        res_t r;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) drive_txn(va[k], 16'hFFFF, 3'd7, vs[k], vm[k]);
        drain();
        total_cnt++; if (obs_q.size() != 7) $display("FAIL acc_count: got %0d want 7", obs_q.size()); else pass_cnt++;
        for (int k = 0; k < 7; k++) begin
            r = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            total_cnt++; if (r.data !== vd[k]) $display("FAIL acc%0d_data: got %h want %h", k, r.data, vd[k]); else pass_cnt++;
            total_cnt++; if (r.cy !== vc[k]) $display("FAIL acc%0d_carry: got %b want %b", k, r.cy, vc[k]); else pass_cnt++;
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int n_acc;
        logic [15:0] held;
        logic stable;
        res_t r;
        do_reset();
        out_ready = 1'b0; n_acc = 0;
        select = 3'd0; sat_en = 1'b0; lane_mask = 4'hF; b = 16'h0;
        for (int k = 0; k < 4; k++) begin
            a = 16'(n_acc + 1); in_valid = 1'b1;
            tick();
            if (smp_accept) n_acc++;
        end
        total_cnt++; if (n_acc != 2) $display("FAIL bp_accepts: got %0d want 2", n_acc); else pass_cnt++;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else pass_cnt++;
        held = data_out; stable = out_valid;
        for (int k = 0; k < 3; k++) begin
            a = 16'(n_acc + 1);
            tick();
            if (smp_accept) n_acc++;
            if (data_out !== held || out_valid !== 1'b1) stable = 1'b0;
        end
        total_cnt++; if (stable !== 1'b1) $display("FAIL bp_hold: got data %h want %h held with out_valid", data_out, held); else pass_cnt++;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a = 16'(n_acc + 1); in_valid = (n_acc < 4);
            tick();
            if (smp_accept) n_acc++;
        end
        drain();
        total_cnt++; if (obs_q.size() != 4) $display("FAIL bp_count: got %0d want 4", obs_q.size()); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            r = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            total_cnt++; if (r.data !== 16'(k + 1)) $display("FAIL bp_order%0d: got %h want %h", k, r.data, 16'(k + 1)); else pass_cnt++;
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int first_acc, first_ov, run, maxrun, n_acc;
        res_t e, o;
        do_reset();
        out_ready = 1'b1;
        first_acc = -1; first_ov = -1; run = 0; maxrun = 0; n_acc = 0;
        for (int k = 0; k < 14; k++) begin
            if (k < 8) begin
                a = 16'($urandom); b = 16'($urandom); select = 3'($urandom_range(0, 7));
                sat_en = 1'($urandom); lane_mask = 4'($urandom); in_valid = 1'b1;
            end else in_valid = 1'b0;
            tick();
            if (smp_accept) begin n_acc++; if (first_acc < 0) first_acc = smp_cyc; end
            if (smp_ovalid) begin
                if (first_ov < 0) first_ov = smp_cyc;
                run++;
                if (run > maxrun) maxrun = run;
            end else run = 0;
        end
        total_cnt++; if (n_acc != 8) $display("FAIL b2b_accepts: got %0d want 8", n_acc); else pass_cnt++;
        total_cnt++; if (first_ov - first_acc != 2) $display("FAIL b2b_latency: got %0d want 2", first_ov - first_acc); else pass_cnt++;
        total_cnt++; if (maxrun != 8) $display("FAIL b2b_run: got %0d want 8", maxrun); else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++; if (o !== e) $display("FAIL b2b_result: got %h want %h", o, e); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        res_t e, o;
        int n;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (!in_valid || smp_accept) begin
                a = 16'($urandom); b = 16'($urandom); select = 3'($urandom_range(0, 7));
                sat_en = 1'($urandom); lane_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            end
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        n = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++; if (o !== e) $display("FAIL rnd_result%0d: got %h want %h", n, o, e); else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_reset_mid();
        res_t r;
        do_reset();
        out_ready = 1'b0; select = 3'd7; sat_en = 1'b0; lane_mask = 4'hF; b = 16'h0;
        a = 16'h1111; in_valid = 1'b1;
        tick();
        a = 16'h2222;
        tick();
        in_valid = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b10) $display("FAIL mid_pre: got valid/ready %b want 10", {out_valid, in_ready});
        else pass_cnt++;
        arst = 1'b1;
        tick();
        arst = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready); else pass_cnt++;
        obs_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        drive_txn(16'h1111, 16'h0, 3'd7, 1'b0, 4'hF);
        drain();
        r = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
        total_cnt++; if (r.data !== 16'h1111) $display("FAIL mid_acc: got %h want 1111", r.data); else pass_cnt++;
    endtask

    initial begin
        arst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        select = '0; sat_en = 1'b0; lane_mask = 4'hF;
        smp_accept = 1'b0; smp_fire = 1'b0; smp_ovalid = 1'b0; smp_cyc = 0;
        for (int i = 0; i < NL; i++) acc_m[i] = 0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_acc();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_vec_pipe.md
Name: alu_vec_pipe

Overview:
Parametrised, pipelined successor to the vectorial ALU. It applies one operation across N_LANES independent WIDTH-bit lanes per transaction. It adds a valid/ready handshake with backpressure, per-lane masking, saturating arithmetic, and a per-lane accumulator mode. It sits between the operand-fetch logic and the result-writeback logic of the vector datapath.

Parameters:
WIDTH, 4, bits per lane (>=2)
N_LANES, 4, number of lanes (>=1)

Ports:
clk  in  1  clock, rising edge
arst  in  1  reset, synchronous, active-high
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
a  in  N_LANES*WIDTH  operand A; lane i = a[i*WIDTH +: WIDTH]
b  in  N_LANES*WIDTH  operand B, same packing
select  in  3  operation code
sat_en  in  1  saturating arithmetic enable
lane_mask  in  N_LANES  1 = lane active
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
data_out  out  N_LANES*WIDTH  per-lane result, same packing
carry_out  out  N_LANES  per-lane raw carry (ADD/ACC) or borrow (SUB), 0 otherwise
a_greater  out  N_LANES  per-lane unsigned a>b
a_equal  out  N_LANES  per-lane a==b
a_less  out  N_LANES  per-lane unsigned a<b

Behaviour:
- Reset (arst=1 at clk edge): both stage valids=0, all accumulators=0, data_out/carry_out/flags=0, out_valid=0. in_ready=1 from the first cycle after reset. Reset overrides any concurrent transfer.
- Ops (unsigned): 000 ADD a+b; 001 SUB a-b; 010 AND; 011 OR; 100 XOR; 101 NOT a; 110 MAX(a,b); 111 ACC acc_i <= acc_i + a_i, result = new acc_i (b ignored).
- Saturation (sat_en=1): ADD/ACC overflow -> all-ones; SUB borrow -> 0. carry_out always reports the raw carry/borrow. The ACC register stores the saturated value.
- Flags: computed from captured a,b for every op.
- Masked lane (mask bit 0): data, carry and flags for that lane = 0; its accumulator is unchanged.
- Pipeline: S1 captures operands and control; S2 computes and registers results. Accept when in_valid & in_ready. out_valid rises exactly 2 cycles after acceptance with no stall.
- Handshake: s2_adv = !s2_valid | out_ready; s1_adv = s1_valid & s2_adv; in_ready = !s1_valid | s2_adv.
- Holding: while out_valid & !out_ready, data_out/flags/carry_out hold stable.
- Throughput: full throughput (1/cycle) when out_ready=1. Results are in order, with no drop or duplicate.
- in_ready is combinational from out_ready (no skid). Capacity is 2 transactions.
- ACC commits only on the S1->S2 transfer, so a stalled ACC never updates twice. Back-to-back ACCs see the previous value (internal forwarding; no hazard visible).
- Simultaneous S2 output and S1->S2 refill in the same cycle is legal.
- Wrap-around: without sat, ADD/SUB/ACC wrap modulo 2^WIDTH.

Test Plan:
(All vectors at WIDTH=4, N_LANES=4, lane_mask=1111 unless stated.)
- ADD: a=0x9F3A, b=0x1234, sat_en=0 -> data_out=0xA16E, carry=0100, a_greater=1101, a_equal=0010, a_less=0000. Same vector with sat_en=1 -> data_out=0xAF6E, carry=0100.
- SUB: a=0x1234, b=0x9F3A, sat_en=0 -> data_out=0x830A, carry=1101. With sat_en=1 -> data_out=0x0000, carry=1101.
- ACC after reset: three ACC ops with a=0x1111 -> outputs 0x1111, 0x2222, 0x3333. Then sat_en=1, two ACC ops with a=0xCCCC -> 0xFFFF, 0xFFFF, carry=1111. Mask 0101 on a further ACC with a=0x1111 -> lanes 1,3 read 0 and their accumulators stay 0xF.
- Backpressure: out_ready=0, in_valid=1 for 4 cycles with ADD a=1,2,3,4 (lane0), b=0 -> in_ready=0 after 2 acceptances. After out_ready=1: outputs 1,2,3,4 in order, each exactly once, data stable while stalled.
- Latency/throughput: out_ready=1, 8 back-to-back transactions -> first out_valid 2 cycles after first accept, then 8 consecutive valid cycles.
- Reset mid-operation: arst=1 while out_valid=1 and S1 full with pending ACC -> next cycle out_valid=0, in_ready=1. A subsequent ACC with a=0x1111 returns 0x1111.
